calc_entry_ctrl: RTL

Sequencing controller for the keypad calculator. It consumes debounced key-press pulses, steers digits into operand A or operand B, and latches the operator. On `=` it computes the result and converts it to BCD over a fixed number of cycles. It also drives the display-select code that the seven-segment scan logic uses to show A, B or the result.

---
 rtl/calc_pkg.sv | 41 ++++
 rtl/calc_entry_ctrl_bin2bcd.sv | 50 +++++
 rtl/calc_entry_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator: state encodings, key codes,
// operator codes and the BCD helper functions.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_FIRST  = 2'd0,
        ST_SECOND = 2'd1,
        ST_CONV   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_EQ  = 4'd13;
    localparam logic [3:0] KEY_BS  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    function automatic logic [15:0] bcd_add3(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int d = 0; d < 4; d++) begin
            if (r[d*4 +: 4] >= 4'd5) begin
                r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
            end else begin
                r[d*4 +: 4] = r[d*4 +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] bcd2bin(input logic [7:0] v);
        return ({3'd0, v[7:4]} * 7'd10) + {3'd0, v[3:0]};
    endfunction

endpackage

// File: rtl/calc_entry_ctrl_bin2bcd.sv
// Iterative double-dabble converter: one load cycle then STEPS shift/add-3 cycles.
// o_done flags the cycle whose edge performs the final step; o_bcd_next is that value.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int STEPS = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [13:0] i_bin,
    output logic        o_done,
    output logic [15:0] o_bcd_next
);

    localparam logic [3:0] STEPS_L = 4'(STEPS);

    logic        r_busy;
    logic [3:0]  r_cnt;
    logic [13:0] r_bin;
    logic [15:0] r_bcd;

    assign o_done     = r_busy && (r_cnt == 4'd1);
    assign o_bcd_next = (bcd_add3(r_bcd) << 1) | {15'd0, r_bin[13]};

    // Load on start, then one shift per cycle until the step count runs out; abort wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= 4'd0;
            r_bin  <= 14'd0;
            r_bcd  <= 16'd0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= 4'd0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= STEPS_L;
            r_bin  <= i_bin;
            r_bcd  <= 16'd0;
        end else if (r_busy) begin
            r_bcd  <= o_bcd_next;
            r_bin  <= {r_bin[12:0], 1'b0};
            r_cnt  <= r_cnt - 4'd1;
            r_busy <= (r_cnt != 4'd1);
        end
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad calculator sequencing controller: operand entry, operator latch,
// arithmetic and BCD result latch. Backspace support is built only when
// CALC_BACKSPACE_EN is defined.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int CONV_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_in,
    output logic [1:0]  dis_sel,
    output logic [1:0]  op_code,
    output logic [7:0]  a_bcd,
    output logic [7:0]  b_bcd,
    output logic [15:0] res_bcd,
    output logic        res_neg,
    output logic        busy
);

`ifdef CALC_BACKSPACE_EN
    localparam logic BS_EN = 1'b1;
`else
    localparam logic BS_EN = 1'b0;
`endif

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_a, r_b, w_a_nxt, w_b_nxt;
    logic [1:0]  r_op, w_op_nxt;
    logic [15:0] r_res, w_res_nxt;
    logic        r_neg, w_neg_nxt, r_neg_pend, r_conv_first, r_busy;
    logic [6:0]  w_a_bin, w_b_bin;
    logic [13:0] w_mag;
    logic        w_digit, w_op, w_eq, w_bs, w_clr, w_done, w_abort;
    logic [15:0] w_bcd_next;

    assign w_digit = key_valid && (key_in <= 4'd9);
    assign w_op    = key_valid && ((key_in == KEY_ADD) || (key_in == KEY_SUB) || (key_in == KEY_MUL));
    assign w_eq    = key_valid && (key_in == KEY_EQ);
    assign w_bs    = key_valid && (key_in == KEY_BS) && BS_EN;
    assign w_clr   = key_valid && (key_in == KEY_CLR);
    assign w_abort = (r_state == ST_CONV) && w_clr;
    assign w_a_bin = bcd2bin(r_a);
    assign w_b_bin = bcd2bin(r_b);

    // Magnitude of the selected operation, sampled by the converter on the CONV entry cycle.
    always_comb begin
        case (r_op)
            OP_ADD:  w_mag = {7'd0, w_a_bin} + {7'd0, w_b_bin};
            OP_SUB:  w_mag = (w_a_bin >= w_b_bin) ? {7'd0, w_a_bin - w_b_bin}
                                                  : {7'd0, w_b_bin - w_a_bin};
            OP_MUL:  w_mag = {7'd0, w_a_bin} * {7'd0, w_b_bin};
            default: w_mag = 14'd0;
        endcase
    end

    bin2bcd_seq #(.STEPS(CONV_CYCLES - 1)) u_bin2bcd (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (r_conv_first),
        .i_abort    (w_abort),
        .i_bin      (w_mag),
        .o_done     (w_done),
        .o_bcd_next (w_bcd_next)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; clear takes priority over everything, including converter done.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FIRST: begin
                if (w_op && !w_clr) w_state_nxt = ST_SECOND;
                else                w_state_nxt = ST_FIRST;
            end
            ST_SECOND: begin
                if (w_clr)                      w_state_nxt = ST_FIRST;
                else if (w_eq)                  w_state_nxt = ST_CONV;
                else if (w_bs && r_b == 8'h00)  w_state_nxt = ST_FIRST;
                else                            w_state_nxt = ST_SECOND;
            end
            ST_CONV: begin
                if (w_clr)       w_state_nxt = ST_FIRST;
                else if (w_done) w_state_nxt = ST_RESULT;
                else             w_state_nxt = ST_CONV;
            end
            ST_RESULT: begin
                if (w_clr || w_digit) w_state_nxt = ST_FIRST;
                else                  w_state_nxt = ST_RESULT;
            end
            default: w_state_nxt = ST_FIRST;
        endcase
    end

    // Next values of the operand, operator and result registers.
    always_comb begin
        w_a_nxt   = r_a;
        w_b_nxt   = r_b;
        w_op_nxt  = r_op;
        w_res_nxt = r_res;
        w_neg_nxt = r_neg;
        if (w_clr) begin
            w_a_nxt   = 8'h00;
            w_b_nxt   = 8'h00;
            w_op_nxt  = OP_ADD;
            w_res_nxt = 16'h0000;
            w_neg_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_FIRST: begin
                    if (w_digit) begin
                        w_a_nxt = {r_a[3:0], key_in};
                    end else if (w_op) begin
                        w_b_nxt  = 8'h00;
                        w_op_nxt = (key_in == KEY_SUB) ? OP_SUB :
                                   (key_in == KEY_MUL) ? OP_MUL : OP_ADD;
                    end else if (w_bs) begin
                        w_a_nxt = {4'd0, r_a[7:4]};
                    end else begin
                        w_a_nxt = r_a;
                    end
                end
                ST_SECOND: begin
                    if (w_digit)                   w_b_nxt = {r_b[3:0], key_in};
                    else if (w_bs && r_b != 8'h00) w_b_nxt = {4'd0, r_b[7:4]};
                    else                           w_b_nxt = r_b;
                end
                ST_CONV: begin
                    if (w_done) begin
                        w_res_nxt = w_bcd_next;
                        w_neg_nxt = r_neg_pend;
                    end else begin
                        w_res_nxt = r_res;
                    end
                end
                ST_RESULT: begin
                    if (w_digit) begin
                        w_a_nxt   = {4'd0, key_in};
                        w_b_nxt   = 8'h00;
                        w_res_nxt = 16'h0000;
                        w_neg_nxt = 1'b0;
                    end else begin
                        w_a_nxt = r_a;
                    end
                end
                default: w_a_nxt = r_a;
            endcase
        end
    end

    // Datapath registers, busy flag and the one-cycle converter start strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= 8'h00;
            r_b          <= 8'h00;
            r_op         <= OP_ADD;
            r_res        <= 16'h0000;
            r_neg        <= 1'b0;
            r_neg_pend   <= 1'b0;
            r_conv_first <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_op         <= w_op_nxt;
            r_res        <= w_res_nxt;
            r_neg        <= w_neg_nxt;
            r_neg_pend   <= r_conv_first ? ((r_op == OP_SUB) && (w_a_bin < w_b_bin)) : r_neg_pend;
            r_conv_first <= (r_state != ST_CONV) && (w_state_nxt == ST_CONV);
            r_busy       <= (w_state_nxt == ST_CONV);
        end
    end

    assign dis_sel = r_state;
    assign op_code = r_op;
    assign a_bcd   = r_a;
    assign b_bcd   = r_b;
    assign res_bcd = r_res;
    assign res_neg = r_neg;
    assign busy    = r_busy;

endmodule
